// File: rtl/red_pitaya_hk_gpio.sv
// Expansion-connector GPIO: NCH banks of DW bits with direction/output registers,
// synchronised and debounced inputs, per-bit edge events and one level interrupt.
module red_pitaya_hk_gpio #(
    parameter int NCH  = 2,
    parameter int DW   = 8,
    parameter int SYNC = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCH*DW-1:0] exp_dat_i,
    output logic [NCH*DW-1:0] exp_dat_o,
    output logic [NCH*DW-1:0] exp_dir_o,
    output logic              irq_o,
    input  logic [31:0]       sys_addr,
    input  logic [31:0]       sys_wdata,
    input  logic              sys_wen,
    input  logic              sys_ren,
    output logic [31:0]       sys_rdata,
    output logic              sys_err,
    output logic              sys_ack
);
    localparam int W = NCH * DW;

    typedef enum logic [2:0] {
        OFF_DIR     = 3'd0,
        OFF_DOUT    = 3'd1,
        OFF_DIN     = 3'd2,
        OFF_RISE_EN = 3'd3,
        OFF_FALL_EN = 3'd4,
        OFF_EVENT   = 3'd5,
        OFF_SET     = 3'd6,
        OFF_CLR     = 3'd7
    } bank_off_e;

    logic [DW-1:0]  dir_q     [NCH];
    logic [DW-1:0]  dout_q    [NCH];
    logic [DW-1:0]  rise_en_q [NCH];
    logic [DW-1:0]  fall_en_q [NCH];
    logic [DW-1:0]  event_q   [NCH];
    logic [DW-1:0]  w1c       [NCH];
    logic [DW-1:0]  ev_set    [NCH];
    logic [W-1:0]   sync_q    [SYNC];
    logic [W-1:0]   syn;
    logic [W-1:0]   smp_q;
    logic [W-1:0]   filt_q;
    logic [W-1:0]   filt_d;
    logic [15:0]    deb_per_q;
    logic [15:0]    tick_cnt;
    logic           tick;
    logic [2:0]     bank;
    bank_off_e      offs;
    logic           bank_hit;
    logic           glob_hit;
    logic           deb_wr;
    logic [NCH-1:0] bank_wr;
    logic [7:0]     irq_sts;
    logic           any_event;
    logic [31:0]    rd_data;
    logic           unused;

    assign bank     = sys_addr[7:5];
    assign offs     = bank_off_e'(sys_addr[4:2]);
    assign bank_hit = (sys_addr[19:8] == 12'h000) && (int'(bank) < NCH);
    assign glob_hit = (sys_addr[19:8] == 12'h001);
    assign deb_wr   = sys_wen && glob_hit && (sys_addr[7:2] == 6'h01);
    assign sys_err  = 1'b0;
    assign unused   = ^{sys_addr[31:20], sys_addr[1:0], sys_wdata};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= exp_dat_i;
            for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign syn  = sync_q[SYNC-1];
    assign tick = (deb_per_q != 16'h0) && (tick_cnt == deb_per_q);

    // A bit only follows syn when it matched the sample from the previous tick.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_cnt <= '0;
            smp_q    <= '0;
            filt_q   <= '0;
            filt_d   <= '0;
        end else begin
            filt_d <= filt_q;
            if (deb_wr || tick || deb_per_q == 16'h0) tick_cnt <= '0;
            else                                      tick_cnt <= tick_cnt + 16'd1;
            if (deb_per_q == 16'h0) begin
                filt_q <= syn;
            end else if (tick) begin
                smp_q  <= syn;
                filt_q <= (filt_q & (syn ^ smp_q)) | (syn & ~(syn ^ smp_q));
            end
        end
    end

    always_comb begin
        bank_wr   = '0;
        exp_dat_o = '0;
        exp_dir_o = '0;
        irq_sts   = '0;
        any_event = 1'b0;
        for (int b = 0; b < NCH; b++) begin
            bank_wr[b] = sys_wen && bank_hit && (int'(bank) == b);
            w1c[b]     = (bank_wr[b] && offs == OFF_EVENT) ? sys_wdata[DW-1:0] : '0;
            ev_set[b]  = (filt_q[b*DW +: DW] & ~filt_d[b*DW +: DW] & rise_en_q[b])
                       | (~filt_q[b*DW +: DW] & filt_d[b*DW +: DW] & fall_en_q[b]);
            exp_dat_o[b*DW +: DW] = dout_q[b];
            exp_dir_o[b*DW +: DW] = dir_q[b];
            irq_sts[b] = |event_q[b];
            any_event  = any_event | irq_sts[b];
        end
    end

    always_comb begin
        rd_data = '0;
        if (glob_hit) begin
            case (sys_addr[7:2])
                6'h00:   rd_data = {16'h0, 8'(NCH), 8'(DW)};
                6'h01:   rd_data = {16'h0, deb_per_q};
                6'h02:   rd_data = {24'h0, irq_sts};
                default: rd_data = '0;
            endcase
        end else if (bank_hit) begin
            for (int b = 0; b < NCH; b++) begin
                if (int'(bank) == b) begin
                    case (offs)
                        OFF_DIR:     rd_data[DW-1:0] = dir_q[b];
                        OFF_DOUT:    rd_data[DW-1:0] = dout_q[b];
                        OFF_DIN:     rd_data[DW-1:0] = filt_q[b*DW +: DW];
                        OFF_RISE_EN: rd_data[DW-1:0] = rise_en_q[b];
                        OFF_FALL_EN: rd_data[DW-1:0] = fall_en_q[b];
                        OFF_EVENT:   rd_data[DW-1:0] = event_q[b];
                        default:     ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < NCH; b++) begin
                dir_q[b]     <= '0;
                dout_q[b]    <= '0;
                rise_en_q[b] <= '0;
                fall_en_q[b] <= '0;
                event_q[b]   <= '0;
            end
            deb_per_q <= '0;
            irq_o     <= 1'b0;
            sys_ack   <= 1'b0;
            sys_rdata <= '0;
        end else begin
            sys_ack   <= sys_wen | sys_ren;
            sys_rdata <= sys_ren ? rd_data : 32'h0;
            irq_o     <= any_event;
            if (deb_wr) deb_per_q <= sys_wdata[15:0];
            for (int b = 0; b < NCH; b++) begin
                // NOTE: the set term is OR-ed after the clear so a new edge survives a same-cycle W1C.
                event_q[b] <= (event_q[b] & ~w1c[b]) | ev_set[b];
                if (bank_wr[b]) begin
                    case (offs)
                        OFF_DIR:     dir_q[b]     <= sys_wdata[DW-1:0];
                        OFF_DOUT:    dout_q[b]    <= sys_wdata[DW-1:0];
                        OFF_RISE_EN: rise_en_q[b] <= sys_wdata[DW-1:0];
                        OFF_FALL_EN: fall_en_q[b] <= sys_wdata[DW-1:0];
                        OFF_SET:     dout_q[b]    <= dout_q[b] | sys_wdata[DW-1:0];
                        OFF_CLR:     dout_q[b]    <= dout_q[b] & ~sys_wdata[DW-1:0];
                        default:     ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_hk_gpio.sv
// Self-checking bench for red_pitaya_hk_gpio: vector table, directed timing
// sequences and a randomized phase checked against a register-level model.
`timescale 1ns/1ps
module tb_red_pitaya_hk_gpio;
    localparam int NCH  = 2;
    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int W    = NCH * DW;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [W-1:0]  exp_dat_i;
    logic [W-1:0]  exp_dat_o;
    logic [W-1:0]  exp_dir_o;
    logic          irq_o;
    logic [31:0]   sys_addr;
    logic [31:0]   sys_wdata;
    logic          sys_wen;
    logic          sys_ren;
    logic [31:0]   sys_rdata;
    logic          sys_err;
    logic          sys_ack;

    red_pitaya_hk_gpio #(.NCH(NCH), .DW(DW), .SYNC(SYNC)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .exp_dat_i (exp_dat_i),
        .exp_dat_o (exp_dat_o),
        .exp_dir_o (exp_dir_o),
        .irq_o     (irq_o),
        .sys_addr  (sys_addr),
        .sys_wdata (sys_wdata),
        .sys_wen   (sys_wen),
        .sys_ren   (sys_ren),
        .sys_rdata (sys_rdata),
        .sys_err   (sys_err),
        .sys_ack   (sys_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t          vecs[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [31:0]   rd;
    logic          seen;
    int            lat;
    int            r_op, r_b, r_o;
    logic [31:0]   r_d;
    logic [W-1:0]  r_nv;

    // Reference model: plain register contents plus the pad level last applied.
    logic [DW-1:0] m_dir  [NCH];
    logic [DW-1:0] m_dout [NCH];
    logic [DW-1:0] m_rise [NCH];
    logic [DW-1:0] m_fall [NCH];
    logic [DW-1:0] m_evt  [NCH];
    logic [W-1:0]  m_pad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sys_addr  = a;
        sys_wdata = d;
        sys_wen   = 1'b1;
        @(posedge clk); #1;
        sys_wen   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        sys_addr = a;
        sys_ren  = 1'b1;
        @(posedge clk); #1;
        sys_ren  = 1'b0;
        d        = sys_rdata;
    endtask

    task automatic add_vec(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] e);
        vecs.push_back('{wr, a, d, e});
    endtask

    function automatic logic [31:0] model_read(input int b, input int o);
        logic [31:0] v;
        v = '0;
        if (b < NCH) begin
            case (o)
                0:       v[DW-1:0] = m_dir[b];
                1:       v[DW-1:0] = m_dout[b];
                2:       v[DW-1:0] = m_pad[b*DW +: DW];
                3:       v[DW-1:0] = m_rise[b];
                4:       v[DW-1:0] = m_fall[b];
                5:       v[DW-1:0] = m_evt[b];
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    function automatic logic [31:0] model_sts();
        logic [31:0] v;
        v = '0;
        for (int b = 0; b < NCH; b++) v[b] = (m_evt[b] != '0);
        return v;
    endfunction

    function automatic logic [31:0] model_vec(input bit dir_sel);
        logic [31:0] v;
        v = '0;
        for (int b = 0; b < NCH; b++) v[b*DW +: DW] = dir_sel ? m_dir[b] : m_dout[b];
        return v;
    endfunction

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_i     = 1'b1;
        sys_addr  = '0;
        sys_wdata = '0;
        sys_wen   = 1'b0;
        sys_ren   = 1'b0;
        exp_dat_i = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_dat_o", {16'h0, exp_dat_o}, 32'h0);
        check("rst_dir_o", {16'h0, exp_dir_o}, 32'h0);
        check("rst_irq",   {31'h0, irq_o}, 32'h0);
        check("rst_ack",   {31'h0, sys_ack}, 32'h0);
        check("rst_rdata", sys_rdata, 32'h0);
        rst_i = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a read transaction drops the ack.
        bus_write(32'h04, 32'hAA);
        bus_write(32'h00, 32'h5A);
        check("pre_rst_dat_o", {16'h0, exp_dat_o}, 32'h00AA);
        sys_addr = 32'h04;
        sys_ren  = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_ack", {31'h0, sys_ack}, 32'h1);
        check("pre_rst_rdata", sys_rdata, 32'hAA);
        #1 rst_i = 1'b1;
        #1;
        check("midrst_ack",   {31'h0, sys_ack}, 32'h0);
        check("midrst_rdata", sys_rdata, 32'h0);
        check("midrst_dat_o", {16'h0, exp_dat_o}, 32'h0);
        check("midrst_dir_o", {16'h0, exp_dir_o}, 32'h0);
        sys_ren = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
        check("idle_ack", {31'h0, sys_ack}, 32'h0);

        // Table: CFG, bank1 output path, write-only reads, out-of-range accesses.
        add_vec(1'b0, 32'h100, 32'h0,   32'h0000_0208);
        add_vec(1'b1, 32'h020, 32'hFF,  32'h0);
        add_vec(1'b1, 32'h024, 32'h0F,  32'h0);
        add_vec(1'b1, 32'h038, 32'h30,  32'h0);
        add_vec(1'b1, 32'h03C, 32'h03,  32'h0);
        add_vec(1'b0, 32'h024, 32'h0,   32'h3C);
        add_vec(1'b0, 32'h020, 32'h0,   32'hFF);
        add_vec(1'b0, 32'h038, 32'h0,   32'h0);
        add_vec(1'b0, 32'h03C, 32'h0,   32'h0);
        add_vec(1'b1, 32'h0A0, 32'hFF,  32'h0);
        add_vec(1'b1, 32'h10C, 32'h55,  32'h0);
        add_vec(1'b0, 32'h0A0, 32'h0,   32'h0);
        add_vec(1'b0, 32'h10C, 32'h0,   32'h0);
        add_vec(1'b1, 32'h224, 32'hFF,  32'h0);
        add_vec(1'b0, 32'h224, 32'h0,   32'h0);
        add_vec(1'b0, 32'h104, 32'h0,   32'h0);
        add_vec(1'b1, 32'h02C, 32'h1FF, 32'h0);
        add_vec(1'b0, 32'h02C, 32'h0,   32'hFF);
        add_vec(1'b1, 32'h02C, 32'h0,   32'h0);
        add_vec(1'b0, 32'h024, 32'h0,   32'h3C);
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_rd_%03h", i, vecs[i].addr), rd, vecs[i].exp);
            end
            check($sformatf("vec%0d_ack", i), {31'h0, sys_ack}, 32'h1);
            check($sformatf("vec%0d_err", i), {31'h0, sys_err}, 32'h0);
        end
        check("out_dat_o", {16'h0, exp_dat_o}, 32'h3C00);
        check("out_dir_o", {16'h0, exp_dir_o}, 32'hFF00);

        // Bypass rise: EVENT at edge SYNC+2, irq_o at SYNC+3.
        bus_write(32'h0C, 32'h01);
        exp_dat_i[0] = 1'b1;
        repeat (SYNC + 1) @(posedge clk); #1;
        bus_read(32'h14, rd);
        check("rise_evt_early", rd, 32'h0);
        check("rise_irq_early", {31'h0, irq_o}, 32'h0);
        bus_read(32'h14, rd);
        check("rise_evt", rd, 32'h1);
        check("rise_irq", {31'h0, irq_o}, 32'h1);
        bus_read(32'h08, rd);
        check("rise_din", rd, 32'h1);
        bus_read(32'h108, rd);
        check("rise_irq_sts", rd, 32'h1);
        bus_write(32'h14, 32'h01);
        check("w1c_irq_hold", {31'h0, irq_o}, 32'h1);
        @(posedge clk); #1;
        check("w1c_irq_low", {31'h0, irq_o}, 32'h0);
        bus_read(32'h14, rd);
        check("w1c_evt", rd, 32'h0);

        // W1C landing on the same edge as a new fall: set wins.
        bus_write(32'h10, 32'h01);
        exp_dat_i[0] = 1'b0;
        repeat (SYNC + 1) @(posedge clk); #1;
        bus_write(32'h14, 32'h01);
        bus_read(32'h14, rd);
        check("set_wins_evt", rd, 32'h1);
        bus_write(32'h14, 32'h01);
        bus_read(32'h14, rd);
        check("set_wins_clr", rd, 32'h0);

        // Debounce with DEB_PER=9: short pulse rejected, long level accepted once.
        bus_write(32'h104, 32'd9);
        bus_read(32'h104, rd);
        check("deb_per_rd", rd, 32'd9);
        bus_write(32'h0C, 32'h02);
        exp_dat_i[1] = 1'b1;
        repeat (5) @(posedge clk); #1;
        exp_dat_i[1] = 1'b0;
        repeat (40) @(posedge clk); #1;
        bus_read(32'h08, rd);
        check("deb_glitch_din", rd, 32'h0);
        bus_read(32'h14, rd);
        check("deb_glitch_evt", rd, 32'h0);
        exp_dat_i[1] = 1'b1;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 40; i++) begin
            if (!seen) begin
                bus_read(32'h08, rd);
                if (rd[1]) begin
                    seen = 1'b1;
                    lat  = i + 1;
                end
            end
        end
        check("deb_seen", {31'h0, seen}, 32'h1);
        check("deb_lat_max", {31'h0, (lat <= 20 + SYNC + 2)}, 32'h1);
        check("deb_lat_min", {31'h0, (lat >= 11)}, 32'h1);
        repeat (10) @(posedge clk); #1;
        bus_read(32'h14, rd);
        check("deb_evt", rd, 32'h2);
        bus_write(32'h14, 32'h02);
        repeat (30) @(posedge clk); #1;
        bus_read(32'h14, rd);
        check("deb_single_evt", rd, 32'h0);
        bus_read(32'h08, rd);
        check("deb_din_hold", rd, 32'h2);

        // Randomized phase in bypass mode against the register model.
        bus_write(32'h104, 32'h0);
        repeat (5) @(posedge clk); #1;
        for (int b = 0; b < NCH; b++) begin
            bus_write(32'(b * 32 + 0),  32'h0);
            bus_write(32'(b * 32 + 4),  32'h0);
            bus_write(32'(b * 32 + 12), 32'h0);
            bus_write(32'(b * 32 + 16), 32'h0);
            bus_write(32'(b * 32 + 20), 32'hFF);
            m_dir[b]  = '0;
            m_dout[b] = '0;
            m_rise[b] = '0;
            m_fall[b] = '0;
            m_evt[b]  = '0;
        end
        m_pad = exp_dat_i;
        @(posedge clk); #1;
        for (int it = 0; it < 80; it++) begin
            r_op = $urandom_range(0, 3);
            if (r_op <= 1) begin
                r_b = $urandom_range(0, 7);
                r_o = $urandom_range(0, 7);
                r_d = $urandom;
                bus_write(32'(r_b * 32 + r_o * 4), r_d);
                if (r_b < NCH) begin
                    case (r_o)
                        0:       m_dir[r_b]  = r_d[DW-1:0];
                        1:       m_dout[r_b] = r_d[DW-1:0];
                        3:       m_rise[r_b] = r_d[DW-1:0];
                        4:       m_fall[r_b] = r_d[DW-1:0];
                        5:       m_evt[r_b]  = m_evt[r_b] & ~r_d[DW-1:0];
                        6:       m_dout[r_b] = m_dout[r_b] | r_d[DW-1:0];
                        7:       m_dout[r_b] = m_dout[r_b] & ~r_d[DW-1:0];
                        default: ;
                    endcase
                end
            end else if (r_op == 2) begin
                r_nv = W'($urandom);
                for (int b = 0; b < NCH; b++) begin
                    m_evt[b] = m_evt[b]
                             | (r_nv[b*DW +: DW] & ~m_pad[b*DW +: DW] & m_rise[b])
                             | (~r_nv[b*DW +: DW] & m_pad[b*DW +: DW] & m_fall[b]);
                end
                m_pad     = r_nv;
                exp_dat_i = r_nv;
                repeat (SYNC + 4) @(posedge clk); #1;
            end
            r_b = $urandom_range(0, 7);
            r_o = $urandom_range(0, 7);
            bus_read(32'(r_b * 32 + r_o * 4), rd);
            check($sformatf("rand%0d_rd_b%0d_o%0d", it, r_b, r_o), rd, model_read(r_b, r_o));
            bus_read(32'h108, rd);
            check($sformatf("rand%0d_irq_sts", it), rd, model_sts());
            check($sformatf("rand%0d_dat_o", it), {16'h0, exp_dat_o}, model_vec(1'b0));
            check($sformatf("rand%0d_dir_o", it), {16'h0, exp_dir_o}, model_vec(1'b1));
            check($sformatf("rand%0d_irq", it), {31'h0, irq_o}, {31'h0, (model_sts() != 32'h0)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/red_pitaya_hk_gpio.md
Name: red_pitaya_hk_gpio

Overview:
Parametrised successor to the fixed two-bank expansion-connector logic in housekeeping. It provides NCH banks of DW GPIO bits, each with direction and output registers and atomic set/clear. Inputs are synchronised and optionally debounced, with per-bit rise/fall edge capture, sticky W1C event registers and a single interrupt output. It sits on the system bus beside housekeeping and drives the expansion connector pads.

Parameters:
NCH, 2, number of GPIO banks (1..8)
DW, 8, bits per bank (1..32)
SYNC, 2, input synchroniser stages (>=2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active high
exp_dat_i  in  NCH*DW  pad input data, bank b = bits [b*DW +: DW]
exp_dat_o  out  NCH*DW  pad output data
exp_dir_o  out  NCH*DW  output enable, 1 = drive
irq_o  out  1  level interrupt, OR of all event bits
sys_addr  in  32  bus address, [19:0] decoded
sys_wdata  in  32  bus write data
sys_wen  in  1  bus write strobe
sys_ren  in  1  bus read strobe
sys_rdata  out  32  bus read data
sys_err  out  1  bus error, tied 0
sys_ack  out  1  bus acknowledge

Behaviour:
- Reset: one clock (clk_i); reset is asynchronous and active-high (rst_i). On reset, all registers, sync/sample/filter flops, events and the tick counter are 0. Outputs reset: exp_dat_o=0, exp_dir_o=0, irq_o=0, sys_rdata=0, sys_ack=0, sys_err=0. Reset mid-transaction drops the pending ack.
- Bank map: base = 0x20*b, b = sys_addr[7:5], offset = sys_addr[4:2]. Only bits [DW-1:0] are used; upper bits write-ignored and read 0.
  - +0x00 DIR rw
  - +0x04 DOUT rw
  - +0x08 DIN ro (filtered)
  - +0x0C RISE_EN rw
  - +0x10 FALL_EN rw
  - +0x14 EVENT r/W1C
  - +0x18 DOUT_SET wo: DOUT |= wdata
  - +0x1C DOUT_CLR wo: DOUT &= ~wdata
  - Write-only registers read 0.
- Global map:
  - 0x100 CFG ro = {16'h0, NCH[7:0], DW[7:0]}
  - 0x104 DEB_PER rw [15:0]
  - 0x108 IRQ_STS ro, bit b = |EVENT[b]
- Bus: sys_ack = registered (sys_wen|sys_ren), so it is high exactly the cycle after the strobe. sys_rdata is registered in the same cycle. Register writes take effect at the strobe edge, so exp_dat_o/exp_dir_o change 1 cycle after sys_wen. Bank b>=NCH, sys_addr[19:9]!=0, and unmapped global offsets are acked, read 0 and write-ignored.
- Input path: SYNC-flop chain per bit produces syn.
- Debounce, DEB_PER==0 (bypass): filt <= syn every cycle.
- Debounce, DEB_PER!=0: a shared tick counter runs 0..DEB_PER, with tick at DEB_PER, then wraps to 0. Writing DEB_PER clears the counter. On each tick: smp <= syn, and per bit filt <= syn when syn==smp. A level must therefore be stable over two consecutive ticks; glitches shorter than one tick period are rejected.
- Edge detect: filt_q = filt delayed 1 cycle.
  - rise = filt & ~filt_q & RISE_EN
  - fall = ~filt & filt_q & FALL_EN
  - EVENT <= (EVENT & ~w1c) | rise | fall. On simultaneous set and W1C of the same bit, set wins.
- irq_o is registered: irq_o <= |(all EVENT), 1 cycle after EVENT.
- Latency, bypass mode, pad edge before clock edge 1:
  - syn at edge SYNC
  - filt/DIN at SYNC+1
  - EVENT at SYNC+2
  - irq_o at SYNC+3
- Enables reset to 0, so a filter 0->1 settle after reset produces no event. Enabling RISE_EN while a pin is already high produces no event (level, not edge).
- DIR does not gate DIN: an output pin reads back its pad value.

Test Plan:
- Reset/CFG: assert rst_i mid-read → sys_ack=0 and all outputs 0. Then read 0x100 → 0x00000208 (NCH=2, DW=8), ack 1 cycle after ren.
- Output: write bank1 DIR=0xFF, DOUT=0x0F, DOUT_SET=0x30, DOUT_CLR=0x03 → exp_dat_o[15:8]=0x3C, exp_dir_o[15:8]=0xFF; read 0x24 → 0x3C; read 0x38 → 0.
- Bypass edge: RISE_EN0=0x01, drive exp_dat_i[0] 0→1 → EVENT0=0x01 at edge SYNC+2, irq_o=1 at SYNC+3, IRQ_STS=0x1. W1C 0x01 to 0x14 → EVENT=0, irq_o=0 next cycle.
- Simultaneous set/clear: time W1C of bit 0 on the same cycle as a new fall (FALL_EN=1) → EVENT bit stays 1.
- Debounce: DEB_PER=9, pulse exp_dat_i[1] high for 5 cycles → no DIN change, no event. Hold high for 30 cycles → DIN0[1]=1 within 2 ticks (≤20+SYNC+1 cycles), single rise event.
- Out-of-range: write bank 5 and address 0x10C → ack, no state change, read 0, sys_err=0.
